// File: rtl/uart_boot_controller.sv
// uart_boot_controller: owns the UART pair after reset, loads the program into
// instruction memory as packed little-endian words, then hands the link to the core.
module uart_boot_controller #(
  parameter int          ADDR_WIDTH = 14,
  parameter logic [7:0]  BOOT_ACK   = 8'h99,
  parameter logic [7:0]  DATA_ACK   = 8'haa
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  rx_ready,
  input  logic [7:0]            rdata,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            sdata,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  input  logic                  cpu_tx_req,
  input  logic [7:0]            cpu_tx_data,
  output logic                  cpu_tx_grant,
  output logic                  cpu_rx_valid,
  output logic [7:0]            cpu_rx_data,
  output logic                  cpu_run,
  output logic                  size_err
);
  typedef enum logic [2:0] {
    SEND_BOOT, WAIT_BOOT, RECV_SIZE, RECV_PROG, SEND_DATA, WAIT_DATA, RUN, ERROR
  } state_t;
  state_t r_state, w_next;
  logic                  r_tx_start, r_grant, r_we, r_rx_valid, r_size_err;
  logic [7:0]            r_sdata, r_rx_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata, r_cnt, r_size, r_word;
  logic                  w_free, w_too_big, w_last, w_size_rx, w_prog_rx;
  logic                  w_send, w_grant, w_write, w_fwd;
  logic [7:0]            w_tx_byte;
  logic [1:0]            w_lane;
  logic [31:0]           w_size_full, w_word;
  // tx_busy lags tx_start by a cycle, so the cycle right after a send is never free
  assign w_free      = ~tx_busy & ~r_tx_start;
  assign w_lane      = r_cnt[1:0];
  assign w_size_full = {rdata, r_size[23:0]};
  assign w_too_big   = {1'b0, w_size_full} > (33'd4 << ADDR_WIDTH);
  assign w_last      = r_cnt == r_size - 32'd1;
  assign w_size_rx   = (r_state == RECV_SIZE) & rx_ready;
  assign w_prog_rx   = (r_state == RECV_PROG) & rx_ready;
  always_comb begin
    w_word = (w_lane == 2'd0) ? '0 : r_word;
    w_word[{w_lane, 3'b000} +: 8] = rdata;
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) r_state <= SEND_BOOT;
    else         r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      SEND_BOOT: w_next = w_free ? WAIT_BOOT : SEND_BOOT;
      WAIT_BOOT: w_next = w_free ? RECV_SIZE : WAIT_BOOT;
      RECV_SIZE: if (w_size_rx && w_lane == 2'd3)
                   w_next = (w_size_full == '0) ? SEND_DATA : w_too_big ? ERROR : RECV_PROG;
      RECV_PROG: w_next = (w_prog_rx && w_last) ? SEND_DATA : RECV_PROG;
      SEND_DATA: w_next = w_free ? WAIT_DATA : SEND_DATA;
      WAIT_DATA: w_next = w_free ? RUN : WAIT_DATA;
      RUN:       w_next = RUN;
      default:   w_next = ERROR;
    endcase
  end
  always_comb begin
    w_grant   = w_free & (r_state == RUN) & cpu_tx_req;
    w_send    = w_grant | (w_free & (r_state == SEND_BOOT || r_state == SEND_DATA));
    w_tx_byte = (r_state == SEND_BOOT) ? BOOT_ACK : (r_state == SEND_DATA) ? DATA_ACK : cpu_tx_data;
    w_write   = w_prog_rx & (w_lane == 2'd3 || w_last);
    w_fwd     = (r_state == RUN) & rx_ready;
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tx_start <= 1'b0;
      r_grant    <= 1'b0;
      r_we       <= 1'b0;
      r_rx_valid <= 1'b0;
      r_size_err <= 1'b0;
      r_sdata    <= '0;
      r_rx_data  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_size     <= '0;
      r_word     <= '0;
    end else begin
      r_tx_start <= w_send;
      r_grant    <= w_grant;
      r_we       <= w_write;
      r_rx_valid <= w_fwd;
      r_size_err <= w_next == ERROR;
      if (w_send) r_sdata <= w_tx_byte;
      if (w_fwd) r_rx_data <= rdata;
      if (w_write) r_wdata <= w_word;
      if (w_prog_rx) r_word <= w_word;
      if (w_size_rx) r_size[{w_lane, 3'b000} +: 8] <= rdata;
      r_addr <= w_size_rx ? '0 : r_we ? r_addr + ADDR_WIDTH'(1) : r_addr;
      r_cnt  <= w_size_rx ? ((w_lane == 2'd3) ? '0 : r_cnt + 32'd1) : w_prog_rx ? r_cnt + 32'd1 : r_cnt;
    end
  end
  assign tx_start     = r_tx_start;
  assign sdata        = r_sdata;
  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign cpu_tx_grant = r_grant;
  assign cpu_rx_valid = r_rx_valid;
  assign cpu_rx_data  = r_rx_data;
  assign cpu_run      = r_state == RUN;
  assign size_err     = r_size_err;
endmodule
